id_ex_decode: RTL and testbench
===============================

Name: id_ex_decode

Overview:
- Instruction decode stage that drives the execute-stage ALU.
- Takes a fetched RV32I instruction plus its PC from the fetch stage.
- Decodes the operand-select and operation controls, immediate, register addresses and memory/branch flags the ALU and downstream stages consume.
- Registers them into the ID/EX pipeline register, with stall and flush control from the hazard unit.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ILLEGAL_AS_BUBBLE, 1, 1: an illegal instruction is issued with all side-effect flags cleared; 0: it is issued with its decoded flags.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instr/pc_in are valid.
- in_ready  out  1  stage accepts input this cycle; equals !stall.
- instr  in  32  instruction word.
- pc_in  in  32  PC of instr.
- stall  in  1  hold the ID/EX register.
- flush  in  1  kill the ID/EX register contents.
- out_valid  out  1  ID/EX register holds a real instruction.
- pc_out  out  32  registered PC.
- rs1_addr, rs2_addr, rd_addr  out  5 each  register addresses.
- reg_write  out  1  rd write enable.
- imm  out  32  sign-extended immediate.
- alu_op  out  3  ALU operation select.
- asrc  out  1  1: A operand is PC; 0: A operand is rs1.
- bsrc  out  1  1: B operand is imm; 0: B operand is rs2.
- sra  out  1  arithmetic right shift.
- shdir  out  1  1: left shift.
- sub  out  1  1: ALU adds; 0: ALU subtracts (fixed ALU polarity).
- jalr  out  1  forces B=4 and target=rs1+imm.
- jal, branch  out  1 each  jump / conditional-branch flags.
- br_funct3  out  3  branch condition.
- mem_read, mem_write  out  1 each  load / store.
- mem_funct3  out  3  access size and sign.
- illegal  out  1  undecodable instruction.

Behaviour:
- Reset (async, rst=1): every output register is 0. in_ready follows !stall combinationally.
- Latency: 1 cycle. Decode is combinational; results are captured on the clk edge.
- Update priority on each edge:
  - flush=1: out_valid<=0 and all flag outputs <=0. Flush wins over stall.
  - else stall=1: all outputs hold.
  - else in_valid=1: capture the decoded fields; out_valid<=1.
  - else: insert a bubble (out_valid=0, all flags 0, other fields 0).
- Immediates: I, S, B, U and J formats per RV32I, sign-extended to 32 bits. U-type is imm[31:12]<<12. Shift-imm gives imm = zero-extended shamt.
- Decode by opcode:
  - OP (0110011): alu_op=funct3, asrc=0, bsrc=0, reg_write=1. sub=0 only for funct3=000 with funct7=0100000, otherwise sub=1. sra=funct7[5] when funct3=101. shdir=1 when funct3=001.
  - OP-IMM (0010011): as OP, but bsrc=1 and sub=1 always. funct7 is checked only for shifts.
  - LOAD (0000011) / STORE (0100011): alu_op=000, sub=1, bsrc=1; mem_funct3=funct3. LOAD sets mem_read=1, reg_write=1; STORE sets mem_write=1, reg_write=0.
  - LUI: rs1_addr forced to 0, bsrc=1, sub=1, alu_op=000.
  - AUIPC: asrc=1, bsrc=1, sub=1, alu_op=000.
  - JAL: jal=1, asrc=1, bsrc=1, sub=1, reg_write=1. The link value PC+4 is formed downstream.
  - JALR: jalr=1, asrc=1, sub=1, reg_write=1. The ALU yields PC+4 and the target rs1+imm.
  - BRANCH (1100011): branch=1, br_funct3=funct3, asrc=0, bsrc=0, reg_write=0.
- Illegal conditions:
  - unknown opcode;
  - OP funct7 not 0000000/0100000;
  - 0100000 with OP funct3 not 000/101;
  - shift-imm funct7 bad;
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 >010.
- On illegal: illegal=1, out_valid=1. With ILLEGAL_AS_BUBBLE=1, reg_write, mem_read, mem_write, branch, jal and jalr are 0.
- rd_addr=0: reg_write may still be 1; the register file ignores writes to x0.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) -> next cycle: alu_op=000, sub=1, asrc=0, bsrc=0, rs1=1, rs2=2, rd=3, reg_write=1, out_valid=1.
- SUB x3,x1,x2 (0x402081B3) -> sub=0. SRAI x5,x6,3 (0x40335293) -> alu_op=101, sra=1, shdir=0, bsrc=1, imm=3.
- BEQ x1,x2,-8 (0xFE208CE3) at pc 0x100 -> branch=1, br_funct3=000, imm=0xFFFFFFF8, reg_write=0, pc_out=0x100.
- JALR x1,4(x5) (0x004280E7) -> jalr=1, asrc=1, imm=4, rs1=5, rd=1, reg_write=1.
- Stall held 2 cycles with new input present -> outputs unchanged. Then stall+flush together -> out_valid=0, reg_write=0.
- 0xFFFFFFFF -> illegal=1, out_valid=1, reg_write=0, mem_write=0. Assert rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_decode.sv
// RV32I instruction decode stage feeding the ID/EX pipeline register.
// Decode is purely combinational. The registered copy updates on clk.
// Update priority is flush, then stall, then capture, then bubble.
module id_ex_decode #(
  parameter int XLEN              = 32,
  parameter bit ILLEGAL_AS_BUBBLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      alu_op,
  output logic            asrc,
  output logic            bsrc,
  output logic            sra,
  output logic            shdir,
  output logic            sub,
  output logic            jalr,
  output logic            jal,
  output logic            branch,
  output logic [2:0]      br_funct3,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      mem_funct3,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // One bundle for everything the ID/EX register carries.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic [XLEN-1:0] imm;
    logic [2:0]      alu_op;
    logic            asrc;
    logic            bsrc;
    logic            sra;
    logic            shdir;
    logic            sub;
    logic            jalr;
    logic            jal;
    logic            branch;
    logic [2:0]      br_funct3;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_funct3;
    logic            illegal;
  } idex_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_sh;
  idex_t           w_dec;
  idex_t           r_q;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];

  assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_u  = {instr[31:12], 12'h000};
  assign w_imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign w_imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};

  // Combinational decode of the incoming instruction into ID/EX fields.
  always_comb begin
    w_dec       = '0;
    w_dec.valid = 1'b1;
    w_dec.pc    = pc_in;
    w_dec.rs1   = instr[19:15];
    w_dec.rs2   = instr[24:20];
    w_dec.rd    = instr[11:7];
    case (w_opcode)
      OPC_OP: begin
        w_dec.alu_op    = w_funct3;
        w_dec.reg_write = 1'b1;
        w_dec.sub       = !((w_funct3 == 3'b000) && (w_funct7 == 7'b0100000));
        w_dec.sra       = (w_funct3 == 3'b101) && w_funct7[5];
        w_dec.shdir     = (w_funct3 == 3'b001);
        w_dec.illegal   = ((w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000)) ||
                          ((w_funct7 == 7'b0100000) && (w_funct3 != 3'b000) &&
                           (w_funct3 != 3'b101));
      end
      OPC_OPIMM: begin
        w_dec.alu_op    = w_funct3;
        w_dec.reg_write = 1'b1;
        w_dec.bsrc      = 1'b1;
        w_dec.sub       = 1'b1;
        w_dec.imm       = w_imm_i;
        if (w_funct3 == 3'b001) begin
          // Left shift only exists with an all-zero upper field.
          w_dec.imm     = w_imm_sh;
          w_dec.shdir   = 1'b1;
          w_dec.illegal = (w_funct7 != 7'b0000000);
        end else if (w_funct3 == 3'b101) begin
          w_dec.imm     = w_imm_sh;
          w_dec.sra     = w_funct7[5];
          w_dec.illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
        end
      end
      OPC_LOAD: begin
        w_dec.bsrc       = 1'b1;
        w_dec.sub        = 1'b1;
        w_dec.imm        = w_imm_i;
        w_dec.mem_funct3 = w_funct3;
        w_dec.mem_read   = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.illegal    = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                           (w_funct3 == 3'b111);
      end
      OPC_STORE: begin
        w_dec.bsrc       = 1'b1;
        w_dec.sub        = 1'b1;
        w_dec.imm        = w_imm_s;
        w_dec.mem_funct3 = w_funct3;
        w_dec.mem_write  = 1'b1;
        w_dec.illegal    = (w_funct3 > 3'b010);
      end
      OPC_LUI: begin
        // x0 + imm lets the ALU pass the upper immediate straight through.
        w_dec.rs1       = 5'd0;
        w_dec.bsrc      = 1'b1;
        w_dec.sub       = 1'b1;
        w_dec.imm       = w_imm_u;
        w_dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.asrc      = 1'b1;
        w_dec.bsrc      = 1'b1;
        w_dec.sub       = 1'b1;
        w_dec.imm       = w_imm_u;
        w_dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_dec.jal       = 1'b1;
        w_dec.asrc      = 1'b1;
        w_dec.bsrc      = 1'b1;
        w_dec.sub       = 1'b1;
        w_dec.imm       = w_imm_j;
        w_dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        // B is forced to 4 downstream, so bsrc stays on rs2.
        w_dec.jalr      = 1'b1;
        w_dec.asrc      = 1'b1;
        w_dec.sub       = 1'b1;
        w_dec.imm       = w_imm_i;
        w_dec.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.branch    = 1'b1;
        w_dec.br_funct3 = w_funct3;
        w_dec.imm       = w_imm_b;
        w_dec.illegal   = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
    if (ILLEGAL_AS_BUBBLE && w_dec.illegal) begin
      w_dec.reg_write = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.branch    = 1'b0;
      w_dec.jal       = 1'b0;
      w_dec.jalr      = 1'b0;
    end
  end

  // ID/EX register: flush beats stall, stall holds, otherwise capture or bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (flush) begin
      r_q <= '0;
    end else if (!stall) begin
      r_q <= in_valid ? w_dec : '0;
    end
  end

  assign in_ready   = !stall;
  assign out_valid  = r_q.valid;
  assign pc_out     = r_q.pc;
  assign rs1_addr   = r_q.rs1;
  assign rs2_addr   = r_q.rs2;
  assign rd_addr    = r_q.rd;
  assign reg_write  = r_q.reg_write;
  assign imm        = r_q.imm;
  assign alu_op     = r_q.alu_op;
  assign asrc       = r_q.asrc;
  assign bsrc       = r_q.bsrc;
  assign sra        = r_q.sra;
  assign shdir      = r_q.shdir;
  assign sub        = r_q.sub;
  assign jalr       = r_q.jalr;
  assign jal        = r_q.jal;
  assign branch     = r_q.branch;
  assign br_funct3  = r_q.br_funct3;
  assign mem_read   = r_q.mem_read;
  assign mem_write  = r_q.mem_write;
  assign mem_funct3 = r_q.mem_funct3;
  assign illegal    = r_q.illegal;

endmodule

// File: tb/tb_id_ex_decode.sv
// Scoreboard bench for id_ex_decode: stimulus pushes expected register
// contents, a monitor pops and compares one cycle after each capture.
module tb_id_ex_decode;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] imm;
    logic [2:0]  alu_op;
    logic        asrc;
    logic        bsrc;
    logic        sra;
    logic        shdir;
    logic        sub;
    logic        jalr;
    logic        jal;
    logic        branch;
    logic [2:0]  br_funct3;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic        illegal;
  } exp_t;

  typedef struct {
    exp_t  e;
    bit    full;
    string name;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] pc_out;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        reg_write;
  logic [31:0] imm;
  logic [2:0]  alu_op;
  logic        asrc, bsrc, sra, shdir, sub, jalr, jal, branch;
  logic [2:0]  br_funct3;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic        illegal;

  int   errors = 0;
  int   checks = 0;
  sb_t  sb_q[$];
  exp_t model;
  bit   model_full;

  id_ex_decode dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .stall(stall), .flush(flush),
    .out_valid(out_valid), .pc_out(pc_out), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rd_addr(rd_addr), .reg_write(reg_write),
    .imm(imm), .alu_op(alu_op), .asrc(asrc), .bsrc(bsrc), .sra(sra),
    .shdir(shdir), .sub(sub), .jalr(jalr), .jal(jal), .branch(branch),
    .br_funct3(br_funct3), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t sample();
    exp_t s;
    s.valid = out_valid; s.pc = pc_out; s.rs1 = rs1_addr; s.rs2 = rs2_addr;
    s.rd = rd_addr; s.reg_write = reg_write; s.imm = imm; s.alu_op = alu_op;
    s.asrc = asrc; s.bsrc = bsrc; s.sra = sra; s.shdir = shdir; s.sub = sub;
    s.jalr = jalr; s.jal = jal; s.branch = branch; s.br_funct3 = br_funct3;
    s.mem_read = mem_read; s.mem_write = mem_write; s.mem_funct3 = mem_funct3;
    s.illegal = illegal;
    return s;
  endfunction

  function automatic logic [7:0] flags_of(input exp_t e);
    return {e.valid, e.reg_write, e.mem_read, e.mem_write,
            e.branch, e.jal, e.jalr, e.illegal};
  endfunction

  // Reference decode written from the instruction-set rules.
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    int vi, vs, vb, vj;
    e = '0;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    vi = i12; vs = s12; vb = b13; vj = j21;
    e.valid = 1; e.pc = pc;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    if (opc == 7'b0110011) begin
      e.alu_op = f3; e.reg_write = 1;
      e.sub = (f3 == 3'd0 && f7 == 7'h20) ? 1'b0 : 1'b1;
      e.sra = (f3 == 3'd5) ? f7[5] : 1'b0;
      e.shdir = (f3 == 3'd1);
      if (!(f7 inside {7'h00, 7'h20})) e.illegal = 1;
      if (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) e.illegal = 1;
    end else if (opc == 7'b0010011) begin
      e.alu_op = f3; e.reg_write = 1; e.bsrc = 1; e.sub = 1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.imm = 32'(ins[24:20]);
        e.shdir = (f3 == 3'd1);
        e.sra = (f3 == 3'd5) ? f7[5] : 1'b0;
        if (f3 == 3'd1 && f7 != 7'h00) e.illegal = 1;
        if (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) e.illegal = 1;
      end else begin
        e.imm = vi;
      end
    end else if (opc == 7'b0000011) begin
      e.bsrc = 1; e.sub = 1; e.imm = vi; e.mem_funct3 = f3;
      e.mem_read = 1; e.reg_write = 1;
      e.illegal = (f3 inside {3'd3, 3'd6, 3'd7});
    end else if (opc == 7'b0100011) begin
      e.bsrc = 1; e.sub = 1; e.imm = vs; e.mem_funct3 = f3; e.mem_write = 1;
      e.illegal = (f3 > 3'd2);
    end else if (opc == 7'b0110111) begin
      e.rs1 = 0; e.bsrc = 1; e.sub = 1; e.imm = ins & 32'hFFFF_F000; e.reg_write = 1;
    end else if (opc == 7'b0010111) begin
      e.asrc = 1; e.bsrc = 1; e.sub = 1; e.imm = ins & 32'hFFFF_F000; e.reg_write = 1;
    end else if (opc == 7'b1101111) begin
      e.jal = 1; e.asrc = 1; e.bsrc = 1; e.sub = 1; e.imm = vj; e.reg_write = 1;
    end else if (opc == 7'b1100111) begin
      e.jalr = 1; e.asrc = 1; e.sub = 1; e.imm = vi; e.reg_write = 1;
    end else if (opc == 7'b1100011) begin
      e.branch = 1; e.br_funct3 = f3; e.imm = vb;
      e.illegal = (f3 inside {3'd2, 3'd3});
    end else begin
      e.illegal = 1;
    end
    if (e.illegal) begin
      e.reg_write = 0; e.mem_read = 0; e.mem_write = 0;
      e.branch = 0; e.jal = 0; e.jalr = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [0:8];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) begin
      w[6:0] = ops[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
    end
    return w;
  endfunction

  // Drive one cycle of inputs and queue the register contents expected after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic st, input logic fl, input string name);
    sb_t it;
    @(negedge clk);
    in_valid = v; instr = ins; pc_in = pc; stall = st; flush = fl;
    if (fl) begin
      model = '0; model_full = 0;
    end else if (!st) begin
      model = v ? model_decode(ins, pc) : '0;
      model_full = 1;
    end
    it.e = model; it.full = model_full; it.name = name;
    sb_q.push_back(it);
    #1;
    checks++;
    if (in_ready !== !st) begin
      errors++;
      $display("FAIL in_ready(%s): got %b expected %b", name, in_ready, !st);
    end
  endtask

  // Monitor: one expected entry per captured edge.
  initial begin
    sb_t  it;
    exp_t got;
    bit   bad;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        got = sample();
        bad = it.full ? (got !== it.e) : (flags_of(got) !== flags_of(it.e));
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, got, it.e);
        end else begin
          $display("ok   %s: valid=%b rw=%b ill=%b imm=%h", it.name, got.valid,
                   got.reg_write, got.illegal, got.imm);
        end
      end
    end
  end

  initial begin
    exp_t got;
    model = '0; model_full = 1;
    #3;
    got = sample();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", got);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    step(1, 32'h002081B3, 32'h0000_0000, 0, 0, "add");
    step(1, 32'h402081B3, 32'h0000_0004, 0, 0, "sub");
    step(1, 32'h40335293, 32'h0000_0008, 0, 0, "srai");
    step(1, 32'hFE208CE3, 32'h0000_0100, 0, 0, "beq_neg");
    step(1, 32'h004280E7, 32'h0000_0104, 0, 0, "jalr");
    step(1, 32'h002081B3, 32'h0000_0200, 1, 0, "stall1");
    step(1, 32'h40335293, 32'h0000_0204, 1, 0, "stall2");
    step(1, 32'h002081B3, 32'h0000_0208, 1, 1, "stall_flush");
    step(1, 32'hFFFFFFFF, 32'h0000_0300, 0, 0, "illegal_ones");
    step(0, 32'h002081B3, 32'h0000_0304, 0, 0, "bubble");
    step(1, 32'h123450B7, 32'h0000_0308, 0, 0, "lui");
    step(1, 32'h0000B183, 32'h0000_030C, 0, 0, "load_bad_f3");
    step(1, 32'h0020B023, 32'h0000_0310, 0, 0, "store_bad_f3");
    step(1, 32'h00001037, 32'h0000_0314, 0, 0, "lui_rd0");

    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 5) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, "rand");
    end

    // Asynchronous reset between edges must clear the register at once.
    step(1, 32'h002081B3, 32'h0000_0400, 0, 0, "pre_reset");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    got = sample();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", got);
    end else begin
      $display("ok   async_reset: outputs cleared");
    end
    model = '0; model_full = 1;
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 100; n++) begin
      step($urandom_range(0, 5) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, "rand2");
    end

    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
